hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline control unit, backward path of the ID->EX stage register: reads the ID/EX
//  register outputs and the IF/ID source fields, and drives the stall, write-enable and
//  flush controls of PC, IF/ID, ID/EX and EX/MEM. Handles load-use stalls, taken-branch
//  flushes and multi-cycle data-memory waits.
// PARAMETERS
//  LOAD_STALL_CYCLES  1    bubble cycles inserted per load-use hazard (1..15)
//  FLUSH_CYCLES       1    cycles IF/ID and ID/EX are flushed after a taken branch (1..15)
//  MEM_TIMEOUT        255  MEM_WAIT cycles before mem_err_o is set (1..65535)
// PORTS
//  clk                in   1   rising-edge clock
//  rst                in   1   asynchronous, active-high reset
//  if_id_rs1_i        in   5   rs1 of instruction in ID
//  if_id_rs2_i        in   5   rs2 of instruction in ID
//  if_id_uses_rs2_i   in   1   ID instruction reads rs2
//  id_ex_MemRead_i    in   1   instruction in EX is a load
//  id_ex_wr_i         in   5   destination register of instruction in EX
//  ex_branch_taken_i  in   1   branch in EX resolved taken
//  mem_req_i          in   1   MEM-stage instruction accesses data memory
//  mem_ready_i        in   1   data memory completes access this cycle
//  pc_write_o         out  1   PC load enable
//  if_id_write_o      out  1   IF/ID load enable
//  if_id_flush_o      out  1   IF/ID loads a NOP
//  id_ex_write_o      out  1   ID/EX load enable
//  id_ex_flush_o      out  1   ID/EX loads a bubble (all control bits 0)
//  ex_mem_write_o     out  1   EX/MEM load enable
//  mem_err_o          out  1   sticky memory-timeout flag
// BEHAVIOUR
//  - States: RUN, LU_STALL, BR_FLUSH, MEM_WAIT. State, 4-bit cycle counter, 16-bit wait
//    counter, saved return state are registered; outputs are a combinational decode of
//    state + inputs (same-cycle response).
//  - rst asserted: state=RUN, counters=0, mem_err_o=0; outputs forced: all *_write_o=0,
//    both *_flush_o=1.
//  - Default (nothing active): all *_write_o=1, flushes 0.
//  - Priority per cycle: memory freeze > branch flush > load-use stall.
//  - Freeze: mem_req_i=1 && mem_ready_i=0 -> all four *_write_o=0, flushes 0; enter
//    MEM_WAIT, saving the current state (RUN/LU_STALL/BR_FLUSH) and its counter.
//  - MEM_WAIT: freeze held; wait counter increments, saturates at MEM_TIMEOUT and sets
//    mem_err_o (cleared only by rst). Cycle with mem_ready_i=1: freeze released, outputs
//    decoded from the saved state, wait counter cleared; next = saved state, saved counter
//    restored.
//  - Branch: ex_branch_taken_i=1 (any state except frozen) -> pc_write_o=1,
//    if_id_flush_o=1, id_ex_flush_o=1; aborts any load-use stall. If FLUSH_CYCLES>1 go
//    BR_FLUSH for FLUSH_CYCLES-1 further flush cycles, else stay RUN.
//  - Load-use: id_ex_MemRead_i && id_ex_wr_i!=0 && (id_ex_wr_i==if_id_rs1_i ||
//    (if_id_uses_rs2_i && id_ex_wr_i==if_id_rs2_i)) -> pc_write_o=0, if_id_write_o=0,
//    id_ex_flush_o=1. If LOAD_STALL_CYCLES>1 go LU_STALL and repeat the same outputs
//    LOAD_STALL_CYCLES-1 more cycles, else stay RUN. x0 never hazards.
//  - Counter reaching 0 in LU_STALL/BR_FLUSH returns to RUN in the following cycle.
//  - Reset mid-stall or mid-wait: immediate return to RUN, no saved state retained.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds ports stall_cnt_o (out, 32) = cycles with
//  pc_write_o=0 outside reset, and flush_cnt_o (out, 32) = cycles with id_ex_flush_o=1
//  outside reset; both saturate at 2^32-1, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Load x5 in EX, ID reads rs1=x5 -> one cycle pc_write_o=0, if_id_write_o=0,
//    id_ex_flush_o=1; next cycle (bubble in EX) all writes 1.
//  2 Load to x0, ID rs1=x0 -> no stall; load x7, ID rs2=x7 with if_id_uses_rs2_i=0 ->
//    no stall.
//  3 ex_branch_taken_i=1 together with load-use hazard -> pc_write_o=1, both flushes 1,
//    no stall; with FLUSH_CYCLES=2 flushes held 2 cycles.
//  4 mem_req_i=1, mem_ready_i=0 for 3 cycles then 1 -> 3 cycles all writes 0, release in
//    the ready cycle; mem_err_o stays 0.
//  5 MEM_TIMEOUT=4, ready withheld 10 cycles -> mem_err_o=1 after 4 wait cycles, sticky
//    after release until rst.
//  6 LOAD_STALL_CYCLES=3, freeze arriving in 2nd stall cycle, rst pulsed mid-wait in a
//    rerun -> stall resumes with 1 cycle left after ready; rst forces RUN outputs at once.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes and data-memory freezes.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] if_id_rs1_i,
    input  logic [4:0] if_id_rs2_i,
    input  logic       if_id_uses_rs2_i,
    input  logic       id_ex_MemRead_i,
    input  logic [4:0] id_ex_wr_i,
    input  logic       ex_branch_taken_i,
    input  logic       mem_req_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       if_id_write_o,
    output logic       if_id_flush_o,
    output logic       id_ex_write_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_write_o,
    output logic       mem_err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WAIT_W = 16;
    localparam logic [CNT_W-1:0]  LS_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FL_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH, MEM_WAIT} state_e;

    state_e             state_q, state_d, ret_q, ret_d, base_st;
    logic [CNT_W-1:0]   cnt_q, cnt_d, ret_cnt_q, ret_cnt_d, base_cnt;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_q, err_d;
    logic               frozen, hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            ret_q     <= RUN;
            ret_cnt_q <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ret_q     <= ret_d;
            ret_cnt_q <= ret_cnt_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
        end
    end

    assign mem_err_o = err_q;

    // The ready cycle of a freeze behaves as a normal cycle of the state that was frozen.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_write_o  = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_write_o = 1'b1;
        state_d        = state_q;
        cnt_d          = cnt_q;
        ret_d          = ret_q;
        ret_cnt_d      = ret_cnt_q;
        wait_d         = wait_q;
        err_d          = err_q;

        base_st  = (state_q == MEM_WAIT) ? ret_q : state_q;
        base_cnt = (state_q == MEM_WAIT) ? ret_cnt_q : cnt_q;
        frozen   = (state_q == MEM_WAIT) ? !mem_ready_i : (mem_req_i && !mem_ready_i);
        hazard   = id_ex_MemRead_i && (id_ex_wr_i != 5'd0) &&
                   ((id_ex_wr_i == if_id_rs1_i) ||
                    (if_id_uses_rs2_i && (id_ex_wr_i == if_id_rs2_i)));

        if (frozen) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            state_d        = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_d     = state_q;
                ret_cnt_d = cnt_q;
            end
            if (wait_q < TIMEOUT) begin
                wait_d = wait_q + WAIT_W'(1);
            end
            if (wait_d == TIMEOUT) begin
                err_d = 1'b1;
            end
        end else begin
            wait_d = '0;
            if (ex_branch_taken_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                state_d       = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
                cnt_d         = FL_LOAD;
            end else begin
                case (base_st)
                    BR_FLUSH: begin
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                        state_d       = (base_cnt <= CNT_W'(1)) ? RUN : BR_FLUSH;
                        cnt_d         = base_cnt - CNT_W'(1);
                    end
                    LU_STALL: begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_flush_o = 1'b1;
                        state_d       = (base_cnt <= CNT_W'(1)) ? RUN : LU_STALL;
                        cnt_d         = base_cnt - CNT_W'(1);
                    end
                    default: begin
                        state_d = RUN;
                        cnt_d   = '0;
                        if (hazard) begin
                            pc_write_o    = 1'b0;
                            if_id_write_o = 1'b0;
                            id_ex_flush_o = 1'b1;
                            state_d       = (LOAD_STALL_CYCLES > 1) ? LU_STALL : RUN;
                            cnt_d         = LS_LOAD;
                        end
                    end
                endcase
            end
        end

        if (rst) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (id_ex_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven in parallel, checked each cycle
// against a remaining-bubble-count reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, wr;
    logic       u2, mr, br, req, rdy;
    logic [6:0] obs [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif

    hazard_ctrl u0 (
        .clk(clk), .rst(rst),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .if_id_uses_rs2_i(u2),
        .id_ex_MemRead_i(mr), .id_ex_wr_i(wr), .ex_branch_taken_i(br),
        .mem_req_i(req), .mem_ready_i(rdy),
        .pc_write_o(obs[0][6]), .if_id_write_o(obs[0][5]), .if_id_flush_o(obs[0][4]),
        .id_ex_write_o(obs[0][3]), .id_ex_flush_o(obs[0][2]), .ex_mem_write_o(obs[0][1]),
        .mem_err_o(obs[0][0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(sc0), .flush_cnt_o(fc0)
`endif
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) u1 (
        .clk(clk), .rst(rst),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2), .if_id_uses_rs2_i(u2),
        .id_ex_MemRead_i(mr), .id_ex_wr_i(wr), .ex_branch_taken_i(br),
        .mem_req_i(req), .mem_ready_i(rdy),
        .pc_write_o(obs[1][6]), .if_id_write_o(obs[1][5]), .if_id_flush_o(obs[1][4]),
        .id_ex_write_o(obs[1][3]), .id_ex_flush_o(obs[1][2]), .ex_mem_write_o(obs[1][1]),
        .mem_err_o(obs[1][0])
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o(sc1), .flush_cnt_o(fc1)
`endif
    );

    int unsigned lp [2] = '{1, 3};
    int unsigned fp [2] = '{1, 2};
    int unsigned tp [2] = '{255, 4};
    string nm [7] = '{"mem_err", "ex_mem_write", "id_ex_flush", "id_ex_write",
                      "if_id_flush", "if_id_write", "pc_write"};

    int unsigned stall_rem [2];
    int unsigned flush_rem [2];
    int unsigned wait_cnt  [2];
    bit          waiting   [2];
    bit          err       [2];

    // Bit order {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, err}.
    task automatic model(input int k, output logic [6:0] e);
        bit hz, frz;
        hz = mr && (wr != 5'd0) && ((wr == rs1) || (u2 && (wr == rs2)));
        if (rst) begin
            e = 7'b0010100;
            stall_rem[k] = 0; flush_rem[k] = 0; wait_cnt[k] = 0;
            waiting[k] = 1'b0; err[k] = 1'b0;
            return;
        end
        e[0] = err[k];
        frz = waiting[k] ? !rdy : (req && !rdy);
        if (frz) begin
            e[6:1] = 6'b000000;
            if (wait_cnt[k] < tp[k]) wait_cnt[k]++;
            if (wait_cnt[k] == tp[k]) err[k] = 1'b1;
            waiting[k] = 1'b1;
        end else begin
            waiting[k] = 1'b0;
            wait_cnt[k] = 0;
            if (br) begin
                e[6:1] = 6'b111111;
                stall_rem[k] = 0;
                flush_rem[k] = fp[k] - 1;
            end else if (flush_rem[k] > 0) begin
                e[6:1] = 6'b111111;
                flush_rem[k]--;
            end else if (stall_rem[k] > 0) begin
                e[6:1] = 6'b000111;
                stall_rem[k]--;
            end else if (hz) begin
                e[6:1] = 6'b000111;
                stall_rem[k] = lp[k] - 1;
            end else begin
                e[6:1] = 6'b110101;
            end
        end
    endtask

    task automatic tick();
        logic [6:0] e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            model(k, e);
            for (int b = 0; b < 7; b++) begin
                checks++;
                assert (obs[k][b] === e[b]) else begin
                    failures++;
                    $error("FAIL %s dut%0d cyc=%0d observed=%b expected=%b",
                           nm[b], k, cyc, obs[k][b], e[b]);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        mr = 0; wr = 0; rs1 = 0; rs2 = 0; u2 = 0; br = 0; req = 0; rdy = 0;
    endtask

    task automatic load_use();
        mr = 1; wr = 5'd5; rs1 = 5'd5;
    endtask

    initial begin
        rst = 1; idle();
        tick(); tick();
        rst = 0;
        tick();
        // load-use on rs1, then bubble
        load_use(); tick();
        idle(); tick(); tick(); tick();
        // x0 load and rs2 without uses_rs2
        mr = 1; wr = 0; rs1 = 0; tick();
        mr = 1; wr = 5'd7; rs1 = 5'd1; rs2 = 5'd7; u2 = 0; tick();
        u2 = 1; tick();
        idle(); tick(); tick();
        // branch together with load-use
        load_use(); br = 1; tick();
        br = 0; tick();
        idle(); tick(); tick();
        // short memory wait
        req = 1; rdy = 0; tick(); tick(); tick();
        rdy = 1; tick();
        idle(); tick();
        // long memory wait: timeout on the small configuration
        req = 1; rdy = 0;
        for (int i = 0; i < 10; i++) tick();
        rdy = 1; tick();
        idle(); tick(); tick(); tick();
        rst = 1; tick();
        rst = 0; tick();
        // freeze during a multi-cycle stall, then release
        load_use(); tick();
        idle(); req = 1; tick(); tick();
        rdy = 1; tick();
        idle(); tick(); tick(); tick();
        // rerun, reset during the wait
        load_use(); tick();
        idle(); req = 1; tick(); tick();
        rst = 1; tick();
        rst = 0; idle(); tick(); tick(); tick();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            wr  = 5'($urandom_range(0, 3));
            u2  = 1'($urandom_range(0, 1));
            mr  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 9) == 0);
            req = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
